// File: rtl/pipeline_pkg.sv
// Shared state encoding, constants and helpers for the pipeline front end.
package pipeline_pkg;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_HOLD  = 2'd1,
      ST_KILL  = 2'd2,
      ST_IDLE  = 2'd3   // reached only when misaligned-fetch exceptions are built in
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
   localparam logic [31:0] DEF_RESET_PC = 32'h8000_0000;
   localparam logic [31:0] DEF_IRQ_VEC  = 32'h8000_0004;
   localparam logic [31:0] DEF_EXC_VEC  = 32'h8000_0008;

   function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: load beats bubble, otherwise the contents are held.
module ifid_reg
   import pipeline_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load_i,
   input  logic        bubble_i,
   input  logic [31:0] instr_i,
   input  logic [31:0] pc_i,
   input  logic        addr_exc_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic        valid_o,
   output logic        addr_exc_o
);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         instr_o    <= NOP_INSTR;
         pc_o       <= '0;
         valid_o    <= 1'b0;
         addr_exc_o <= 1'b0;
      end else if (load_i) begin
         instr_o    <= instr_i;
         pc_o       <= pc_i;
         valid_o    <= 1'b1;
         addr_exc_o <= addr_exc_i;
      end else if (bubble_i) begin
         instr_o    <= NOP_INSTR;
         pc_o       <= '0;
         valid_o    <= 1'b0;
         addr_exc_o <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem handshake and IF/ID register, no delay slot.
// Build option IF_MISALIGN_EXC_EN: flag misaligned redirect targets instead of aligning them.
module fetch_unit
   import pipeline_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEF_RESET_PC,
   parameter logic [31:0] IRQ_VEC  = DEF_IRQ_VEC,
   parameter logic [31:0] EXC_VEC  = DEF_EXC_VEC
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   input  logic        exc_redirect,
   input  logic        exc_is_irq,
   output logic [31:0] IFID_Instruction,
   output logic [31:0] IFID_PC,
   output logic        IFID_Valid,
   output logic        IFID_AddrExc
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  pc_next_q, pc_next_d;
   logic [31:0]  buf_q, buf_d;

   logic         take_redir;
   logic [31:0]  raw_tgt, redir_tgt;
   logic         ifid_load, ifid_bubble, ifid_exc;
   logic [31:0]  ifid_instr, ifid_pc;
`ifdef IF_MISALIGN_EXC_EN
   logic         misalign;
`endif

   always_comb begin
      take_redir = exc_redirect | redirect;
      raw_tgt    = redirect_target;
      if (exc_redirect) raw_tgt = exc_is_irq ? IRQ_VEC : EXC_VEC;
`ifdef IF_MISALIGN_EXC_EN
      redir_tgt = raw_tgt;
      misalign  = !exc_redirect && redirect && (redirect_target[1:0] != 2'b00);
`else
      redir_tgt = raw_tgt & 32'hFFFF_FFFC;
`endif
   end

   assign imem_req  = reset && ((state_q == ST_FETCH) || (state_q == ST_KILL));
   assign imem_addr = pc_q;

   // NOTE: every variable driven here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      pc_next_d   = pc_next_q;
      buf_d       = buf_q;
      ifid_load   = 1'b0;
      ifid_bubble = 1'b0;
      ifid_instr  = NOP_INSTR;
      ifid_pc     = pc_q;
      ifid_exc    = 1'b0;

`ifdef IF_MISALIGN_EXC_EN
      if (state_q == ST_IDLE) begin
         if (exc_redirect) begin
            pc_d        = redir_tgt;
            state_d     = ST_FETCH;
            ifid_bubble = 1'b1;
         end else begin
            ifid_bubble = !stall;
         end
      end else if (misalign) begin
         // Any outstanding request is abandoned, as on reset.
         ifid_load = 1'b1;
         ifid_pc   = redirect_target;
         ifid_exc  = 1'b1;
         state_d   = ST_IDLE;
      end else
`endif
      if (take_redir) begin
         ifid_bubble = 1'b1;
         if ((state_q != ST_HOLD) && !imem_ready) begin
            pc_next_d = redir_tgt;
            state_d   = ST_KILL;
         end else begin
            pc_d    = redir_tgt;
            state_d = ST_FETCH;
         end
      end else begin
         unique case (state_q)
            ST_FETCH: begin
               if (imem_ready && !stall) begin
                  ifid_load  = 1'b1;
                  ifid_instr = imem_rdata;
                  pc_d       = pc_plus4(pc_q);
               end else if (imem_ready) begin
                  buf_d   = imem_rdata;
                  state_d = ST_HOLD;
               end else begin
                  ifid_bubble = !stall;
               end
            end
            ST_HOLD: begin
               if (!stall) begin
                  ifid_load  = 1'b1;
                  ifid_instr = buf_q;
                  pc_d       = pc_plus4(pc_q);
                  state_d    = ST_FETCH;
               end
            end
            ST_KILL: begin
               ifid_bubble = !stall;
               if (imem_ready) begin
                  pc_d    = pc_next_q;
                  state_d = ST_FETCH;
               end
            end
            default: state_d = ST_FETCH;
         endcase
      end
   end

   // NOTE: the instruction buffer is a plain register, so it is cleared on
   // reset along with the rest of the state.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_FETCH;
         pc_q      <= RESET_PC;
         pc_next_q <= '0;
         buf_q     <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pc_next_q <= pc_next_d;
         buf_q     <= buf_d;
      end
   end

   ifid_reg u_ifid_reg (
      .clk        (clk),
      .reset      (reset),
      .load_i     (ifid_load),
      .bubble_i   (ifid_bubble),
      .instr_i    (ifid_instr),
      .pc_i       (ifid_pc),
      .addr_exc_i (ifid_exc),
      .instr_o    (IFID_Instruction),
      .pc_o       (IFID_PC),
      .valid_o    (IFID_Valid),
      .addr_exc_o (IFID_AddrExc)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a behavioural fetch model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h8000_0000;
   localparam logic [31:0] IRQ_V  = 32'h8000_0004;
   localparam logic [31:0] EXC_V  = 32'h8000_0008;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_target;
   logic        exc_redirect;
   logic        exc_is_irq;
   logic [31:0] IFID_Instruction;
   logic [31:0] IFID_PC;
   logic        IFID_Valid;
   logic        IFID_AddrExc;

   int n_tests = 0;
   int n_fail  = 0;

   fetch_unit dut (
      .clk              (clk),
      .reset            (reset),
      .imem_req         (imem_req),
      .imem_addr        (imem_addr),
      .imem_ready       (imem_ready),
      .imem_rdata       (imem_rdata),
      .stall            (stall),
      .redirect         (redirect),
      .redirect_target  (redirect_target),
      .exc_redirect     (exc_redirect),
      .exc_is_irq       (exc_is_irq),
      .IFID_Instruction (IFID_Instruction),
      .IFID_PC          (IFID_PC),
      .IFID_Valid       (IFID_Valid),
      .IFID_AddrExc     (IFID_AddrExc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents: every word is a fixed scramble of its own address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_5A5A;
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_addr;      // address being requested, or to request next
   logic [31:0] m_resume;    // where fetching continues once a stale word is dropped
   logic [31:0] m_held;      // word accepted from memory while decode was stalled
   bit          m_has_held, m_dropping, m_halted;
   logic [31:0] e_instr, e_pc;
   bit          e_valid, e_exc;

   function automatic bit exp_req();
      return reset && !m_has_held && !m_halted;
   endfunction

   task automatic m_bubble();
      e_instr = 32'h0; e_pc = 32'h0; e_valid = 1'b0; e_exc = 1'b0;
   endtask

   task automatic m_deliver(input logic [31:0] w, input logic [31:0] a);
      e_instr = w; e_pc = a; e_valid = 1'b1; e_exc = 1'b0;
   endtask

   always @(posedge clk) begin
      bit          busy, got, bad;
      logic [31:0] tgt;
      if (!reset) begin
         m_addr = RST_PC; m_resume = '0; m_held = '0;
         m_has_held = 0; m_dropping = 0; m_halted = 0;
         m_bubble();
      end else begin
         busy = !m_has_held && !m_halted;
         got  = busy && imem_ready;
         tgt  = exc_redirect ? (exc_is_irq ? IRQ_V : EXC_V) : redirect_target;
`ifdef IF_MISALIGN_EXC_EN
         bad  = !exc_redirect && redirect && (redirect_target[1:0] != 2'b00);
`else
         bad  = 1'b0;
         tgt  = {tgt[31:2], 2'b00};
`endif
         if (m_halted) begin
            if (exc_redirect) begin
               m_addr = tgt; m_halted = 0; m_bubble();
            end else if (!stall) m_bubble();
         end else if (bad) begin
            m_halted = 1; m_has_held = 0; m_dropping = 0;
            e_instr = 32'h0; e_pc = redirect_target; e_valid = 1'b1; e_exc = 1'b1;
         end else if (exc_redirect || redirect) begin
            m_bubble();
            if (busy && !got) begin
               m_dropping = 1; m_resume = tgt;
            end else begin
               m_addr = tgt; m_dropping = 0; m_has_held = 0;
            end
         end else if (m_dropping) begin
            if (got) begin m_dropping = 0; m_addr = m_resume; end
            if (!stall) m_bubble();
         end else if (m_has_held) begin
            if (!stall) begin
               m_deliver(m_held, m_addr); m_addr = m_addr + 32'd4; m_has_held = 0;
            end
         end else if (got) begin
            if (stall) begin
               m_held = mem_word(m_addr); m_has_held = 1;
            end else begin
               m_deliver(mem_word(m_addr), m_addr); m_addr = m_addr + 32'd4;
            end
         end else if (!stall) m_bubble();
      end
   end

   // Compare process: outputs are checked 1 time unit after each rising edge.
   initial begin
      forever begin
         @(posedge clk); #1;
         check("cyc_imem_req", {31'b0, imem_req}, {31'b0, exp_req()});
         if (exp_req()) check("cyc_imem_addr", imem_addr, m_addr);
         check("cyc_ifid_valid", {31'b0, IFID_Valid}, {31'b0, e_valid});
         check("cyc_ifid_pc", IFID_PC, e_pc);
         check("cyc_ifid_instr", IFID_Instruction, e_instr);
         check("cyc_ifid_addrexc", {31'b0, IFID_AddrExc}, {31'b0, e_exc});
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input bit rst, input bit rdy, input bit st, input bit rd,
                       input logic [31:0] tg, input bit ex, input bit irq);
      @(negedge clk);
      reset = rst; imem_ready = rdy; stall = st; redirect = rd;
      redirect_target = tg; exc_redirect = ex; exc_is_irq = irq;
      @(posedge clk); #2;
   endtask

   initial begin
      reset = 1'b0; imem_ready = 1'b0; stall = 1'b0; redirect = 1'b0;
      redirect_target = '0; exc_redirect = 1'b0; exc_is_irq = 1'b0;

      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0);
      check("rst_valid", {31'b0, IFID_Valid}, 32'd0);
      check("rst_pc", IFID_PC, 32'h0);
      check("rst_req", {31'b0, imem_req}, 32'd0);

      // Streaming fetch, one word per cycle.
      step(1, 1, 0, 0, 0, 0, 0);
      check("seq0_pc", IFID_PC, 32'h8000_0000);
      check("seq0_instr", IFID_Instruction, 32'hDA5A_5A5A);
      check("seq0_valid", {31'b0, IFID_Valid}, 32'd1);
      check("seq0_addr", imem_addr, 32'h8000_0004);
      step(1, 1, 0, 0, 0, 0, 0);
      check("seq1_pc", IFID_PC, 32'h8000_0004);
      check("seq1_addr", imem_addr, 32'h8000_0008);

      // Three stalled cycles with ready high: word buffered, no request.
      step(1, 1, 1, 0, 0, 0, 0);
      check("hold_req", {31'b0, imem_req}, 32'd0);
      check("hold_pc", IFID_PC, 32'h8000_0004);
      step(1, 1, 1, 0, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0);
      check("unhold_pc", IFID_PC, 32'h8000_0008);
      check("unhold_instr", IFID_Instruction, 32'hDA5A_5A52);
      check("unhold_addr", imem_addr, 32'h8000_000C);

      // Redirect while the request is outstanding: late word dropped.
      step(1, 0, 0, 1, 32'h8000_0100, 0, 0);
      check("kill_valid", {31'b0, IFID_Valid}, 32'd0);
      check("kill_addr", imem_addr, 32'h8000_000C);
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0);
      check("kill_valid2", {31'b0, IFID_Valid}, 32'd0);
      check("kill_newaddr", imem_addr, 32'h8000_0100);
      step(1, 1, 0, 0, 0, 0, 0);
      check("kill_tgt_pc", IFID_PC, 32'h8000_0100);

      // Interrupt beats a simultaneous branch.
      step(1, 1, 0, 1, 32'h8000_0200, 1, 1);
      check("irq_addr", imem_addr, 32'h8000_0004);
      check("irq_valid", {31'b0, IFID_Valid}, 32'd0);
      step(1, 1, 0, 0, 0, 0, 0);
      check("irq_pc", IFID_PC, 32'h8000_0004);
      step(1, 1, 0, 0, 0, 0, 0);

      // Exception during a pending kill replaces the branch target.
      step(1, 0, 0, 1, 32'h8000_0300, 0, 0);
      step(1, 0, 0, 0, 0, 1, 0);
      check("kill2_addr", imem_addr, 32'h8000_000C);
      step(1, 1, 0, 0, 0, 0, 0);
      check("exc_addr", imem_addr, 32'h8000_0008);

      // Redirect beats stall while holding a buffered word.
      step(1, 1, 1, 0, 0, 0, 0);
      step(1, 0, 1, 1, 32'h8000_0400, 0, 0);
      check("holdredir_addr", imem_addr, 32'h8000_0400);
      check("holdredir_req", {31'b0, imem_req}, 32'd1);

      // PC increment wraps at 2^32.
      step(1, 1, 0, 1, 32'hFFFF_FFFC, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0);
      check("wrap_pc", IFID_PC, 32'hFFFF_FFFC);
      check("wrap_addr", imem_addr, 32'h0000_0000);

      // Misaligned redirect target.
      step(1, 1, 0, 1, 32'h8000_0102, 0, 0);
`ifdef IF_MISALIGN_EXC_EN
      check("mis_exc", {31'b0, IFID_AddrExc}, 32'd1);
      check("mis_pc", IFID_PC, 32'h8000_0102);
      check("mis_req", {31'b0, imem_req}, 32'd0);
      step(1, 1, 0, 0, 0, 0, 0);
      check("mis_idle_req", {31'b0, imem_req}, 32'd0);
      step(1, 1, 0, 0, 0, 1, 0);
      check("mis_exit_addr", imem_addr, 32'h8000_0008);
`else
      check("mis_addr", imem_addr, 32'h8000_0100);
      check("mis_exc", {31'b0, IFID_AddrExc}, 32'd0);
      step(1, 1, 0, 0, 0, 0, 0);
      check("mis_pc", IFID_PC, 32'h8000_0100);
`endif

      // Stall with no data holds IF/ID; no data and no stall gives a bubble.
      step(1, 1, 0, 0, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0, 0);
      check("nordy_stall_valid", {31'b0, IFID_Valid}, 32'd1);
      step(1, 0, 0, 0, 0, 0, 0);
      check("nordy_bubble", {31'b0, IFID_Valid}, 32'd0);

      // Reset while holding a buffered word.
      step(1, 1, 1, 0, 0, 0, 0);
      check("prerst_req", {31'b0, imem_req}, 32'd0);
      step(0, 1, 1, 0, 0, 0, 0);
      check("rst2_valid", {31'b0, IFID_Valid}, 32'd0);
      check("rst2_pc", IFID_PC, 32'h0);
      check("rst2_req", {31'b0, imem_req}, 32'd0);
      step(1, 1, 0, 0, 0, 0, 0);
      check("rst2_first_pc", IFID_PC, 32'h8000_0000);
      check("rst2_first_valid", {31'b0, IFID_Valid}, 32'd1);
      step(1, 1, 0, 0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
